// File: rtl/sort_stats.sv
// Statistics collector for ascending-sorted Avalon-ST packets: stores one packet in a
// local RAM, then reports min, max, lower median, length, sum and error flags.
module sort_stats #(
  parameter  int DWIDTH      = 8,
  parameter  int MAX_PKT_LEN = 1024,
  localparam int ADDR_W      = $clog2(MAX_PKT_LEN),
  localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1),
  localparam int SUM_W       = DWIDTH + ADDR_W
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              res_ready_i,
  output logic              res_valid_o,
  output logic [DWIDTH-1:0] res_min_o,
  output logic [DWIDTH-1:0] res_max_o,
  output logic [DWIDTH-1:0] res_median_o,
  output logic [LEN_W-1:0]  res_len_o,
  output logic [SUM_W-1:0]  res_sum_o,
  output logic              res_order_err_o,
  output logic              res_trunc_err_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    OUT     = 3'd4
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DWIDTH-1:0]  min_q, min_d, max_q, max_d, prev_q, prev_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               oerr_q, oerr_d, terr_q, terr_d;
  logic               snk_ready_q, snk_ready_d, res_valid_q, res_valid_d;
  logic [DWIDTH-1:0]  res_min_q, res_min_d, res_max_q, res_max_d, res_med_q, res_med_d;
  logic [LEN_W-1:0]   res_len_q, res_len_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;
  logic               res_oerr_q, res_oerr_d, res_terr_q, res_terr_d;

  logic               accept_s, we_s;
  logic [ADDR_W-1:0]  waddr_s, raddr_s;
  logic [LEN_W-1:0]   mid_s;
  logic [DWIDTH-1:0]  mem [MAX_PKT_LEN];
  logic [DWIDTH-1:0]  rdata_q;

  assign accept_s = snk_valid_i && snk_ready_q;
  assign mid_s    = (len_q - LEN_W'(1)) >> 1;
  assign raddr_s  = mid_s[ADDR_W-1:0];

  // Next-state, statistics update and RAM write control
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    min_d      = min_q;
    max_d      = max_q;
    prev_d     = prev_q;
    sum_d      = sum_q;
    oerr_d     = oerr_q;
    terr_d     = terr_q;
    res_min_d  = res_min_q;
    res_max_d  = res_max_q;
    res_med_d  = res_med_q;
    res_len_d  = res_len_q;
    res_sum_d  = res_sum_q;
    res_oerr_d = res_oerr_q;
    res_terr_d = res_terr_q;
    we_s       = 1'b0;
    waddr_s    = '0;
    case (state_q)
      IDLE, RECV: begin
        if (accept_s && snk_startofpacket_i) begin
          // A SOP while already receiving aborts the old packet and flags the new one.
          we_s    = 1'b1;
          waddr_s = '0;
          len_d   = LEN_W'(1);
          min_d   = snk_data_i;
          max_d   = snk_data_i;
          prev_d  = snk_data_i;
          sum_d   = SUM_W'(snk_data_i);
          oerr_d  = 1'b0;
          terr_d  = (state_q == RECV);
          state_d = snk_endofpacket_i ? RD_ADDR : RECV;
        end else if (accept_s && (state_q == RECV)) begin
          if (len_q < MAX_LEN) begin
            we_s    = 1'b1;
            waddr_s = len_q[ADDR_W-1:0];
            len_d   = len_q + LEN_W'(1);
            sum_d   = sum_q + SUM_W'(snk_data_i);
            min_d   = (snk_data_i < min_q) ? snk_data_i : min_q;
            max_d   = (snk_data_i > max_q) ? snk_data_i : max_q;
          end else begin
            terr_d  = 1'b1;
          end
          if (snk_data_i < prev_q) begin
            oerr_d = 1'b1;
          end else begin
            oerr_d = oerr_q;
          end
          prev_d  = snk_data_i;
          state_d = snk_endofpacket_i ? RD_ADDR : RECV;
        end else begin
          state_d = state_q;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        res_min_d  = min_q;
        res_max_d  = max_q;
        res_med_d  = rdata_q;
        res_len_d  = len_q;
        res_sum_d  = sum_q;
        res_oerr_d = oerr_q;
        res_terr_d = terr_q;
        state_d    = OUT;
      end
      OUT: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
    snk_ready_d = (state_d == IDLE) || (state_d == RECV);
    res_valid_d = (state_d == OUT);
  end

  // State, statistics and registered output flops
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      prev_q      <= '0;
      sum_q       <= '0;
      oerr_q      <= 1'b0;
      terr_q      <= 1'b0;
      snk_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_min_q   <= '0;
      res_max_q   <= '0;
      res_med_q   <= '0;
      res_len_q   <= '0;
      res_sum_q   <= '0;
      res_oerr_q  <= 1'b0;
      res_terr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      min_q       <= min_d;
      max_q       <= max_d;
      prev_q      <= prev_d;
      sum_q       <= sum_d;
      oerr_q      <= oerr_d;
      terr_q      <= terr_d;
      snk_ready_q <= snk_ready_d;
      res_valid_q <= res_valid_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_med_q   <= res_med_d;
      res_len_q   <= res_len_d;
      res_sum_q   <= res_sum_d;
      res_oerr_q  <= res_oerr_d;
      res_terr_q  <= res_terr_d;
    end
  end

  // Packet RAM: one write port, synchronous read with one cycle of latency
  always_ff @(posedge clk_i) begin
    if (we_s) begin
      mem[waddr_s] <= snk_data_i;
    end
    rdata_q <= mem[raddr_s];
  end

  assign snk_ready_o     = snk_ready_q;
  assign res_valid_o     = res_valid_q;
  assign res_min_o       = res_min_q;
  assign res_max_o       = res_max_q;
  assign res_median_o    = res_med_q;
  assign res_len_o       = res_len_q;
  assign res_sum_o       = res_sum_q;
  assign res_order_err_o = res_oerr_q;
  assign res_trunc_err_o = res_terr_q;

endmodule
